// File: rtl/sobel_window_controller.sv
// Raster-to-3x3 window sequencer for sobel_operator. It keeps two line buffers, zero-pads
// every border, and delays window coordinates so they line up with the operator's gradients.
module sobel_window_controller #(
    parameter int IMG_W     = 256,
    parameter int IMG_H     = 256,
    parameter int SOBEL_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [7:0]  p00,
    output logic [7:0]  p01,
    output logic [7:0]  p02,
    output logic [7:0]  p10,
    output logic [7:0]  p11,
    output logic [7:0]  p12,
    output logic [7:0]  p20,
    output logic [7:0]  p21,
    output logic [7:0]  p22,
    output logic        win_valid,
    input  logic [7:0]  grad_mag,
    input  logic        grad_dir,
    output logic        out_valid,
    output logic [7:0]  out_mag,
    output logic        out_dir,
    output logic [15:0] out_x,
    output logic [15:0] out_y,
    output logic        busy,
    output logic        frame_done
);
    localparam int          AW        = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [15:0] COL_LAST  = 16'(IMG_W - 1);
    localparam logic [15:0] ROW_LAST  = 16'(IMG_H - 1);
    localparam logic [15:0] FLUSH_END = 16'(IMG_W);
    localparam logic [15:0] DRAIN_END = 16'(SOBEL_LAT);

    typedef enum logic [2:0] {
        ST_IDLE, ST_PRIME, ST_RUN, ST_PAD, ST_FLUSH, ST_DRAIN
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] col_reg, col_next;
    logic [15:0] row_reg, row_next;
    logic [15:0] drain_reg, drain_next;
    logic        frame_done_reg, frame_done_next;
    logic        accept, lb_we, shift_en, issue, win_clear;
    logic [7:0]  col_in [3];
    logic [15:0] win_x_next, win_y_next;

    logic [7:0]  lb_a [IMG_W];
    logic [7:0]  lb_b [IMG_W];
    logic [7:0]  rd_a_reg, rd_b_reg;

    logic [7:0]  win_reg [3][3];
    logic        win_valid_reg;
    logic [15:0] win_x_reg, win_y_reg;

    logic        dly_valid_reg [SOBEL_LAT];
    logic [15:0] dly_x_reg [SOBEL_LAT];
    logic [15:0] dly_y_reg [SOBEL_LAT];

    logic        out_valid_reg, out_dir_reg;
    logic [7:0]  out_mag_reg;
    logic [15:0] out_x_reg, out_y_reg;

    assign pix_ready = (state_reg == ST_PRIME) || (state_reg == ST_RUN);
    assign accept    = pix_valid & pix_ready;

    always_comb begin
        state_next      = state_reg;
        col_next        = col_reg;
        row_next        = row_reg;
        drain_next      = drain_reg;
        frame_done_next = 1'b0;
        lb_we           = 1'b0;
        shift_en        = 1'b0;
        issue           = 1'b0;
        win_clear       = 1'b0;
        col_in[0]       = 8'h00;
        col_in[1]       = 8'h00;
        col_in[2]       = 8'h00;
        win_x_next      = (state_reg == ST_PAD) ? COL_LAST : col_reg - 16'd1;
        win_y_next      = row_reg - 16'd1;
        case (state_reg)
            ST_IDLE: begin
                // A start landing on the frame_done cycle is dropped on purpose.
                if (start && !frame_done_reg) begin
                    state_next = ST_PRIME;
                    col_next   = 16'd0;
                    row_next   = 16'd0;
                    drain_next = 16'd0;
                    win_clear  = 1'b1;
                end
            end
            ST_PRIME: begin
                if (accept) begin
                    lb_we = 1'b1;
                    if (col_reg == COL_LAST) begin
                        col_next   = 16'd0;
                        row_next   = 16'd1;
                        state_next = ST_RUN;
                    end else begin
                        col_next = col_reg + 16'd1;
                    end
                end
            end
            ST_RUN: begin
                if (accept) begin
                    lb_we     = 1'b1;
                    shift_en  = 1'b1;
                    issue     = (col_reg != 16'd0);
                    col_in[0] = (row_reg == 16'd1) ? 8'h00 : rd_a_reg;
                    col_in[1] = rd_b_reg;
                    col_in[2] = pix_in;
                    if (col_reg == COL_LAST) begin
                        col_next   = 16'd0;
                        state_next = ST_PAD;
                    end else begin
                        col_next = col_reg + 16'd1;
                    end
                end
            end
            ST_PAD: begin
                shift_en   = 1'b1;
                issue      = 1'b1;
                row_next   = row_reg + 16'd1;
                state_next = (row_reg == ROW_LAST) ? ST_FLUSH : ST_RUN;
            end
            ST_FLUSH: begin
                // Row counter sits at IMG_H here, so win_y_next still names the last row.
                shift_en = 1'b1;
                issue    = (col_reg != 16'd0);
                if (col_reg == FLUSH_END) begin
                    drain_next = 16'd0;
                    state_next = ST_DRAIN;
                end else begin
                    col_in[0] = rd_a_reg;
                    col_in[1] = rd_b_reg;
                    col_next  = col_reg + 16'd1;
                end
            end
            ST_DRAIN: begin
                // One extra cycle so frame_done lands with the final captured output.
                if (drain_reg == DRAIN_END) begin
                    frame_done_next = 1'b1;
                    state_next      = ST_IDLE;
                end else begin
                    drain_next = drain_reg + 16'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            col_reg        <= 16'd0;
            row_reg        <= 16'd0;
            drain_reg      <= 16'd0;
            frame_done_reg <= 1'b0;
            win_valid_reg  <= 1'b0;
            win_x_reg      <= 16'd0;
            win_y_reg      <= 16'd0;
        end else begin
            state_reg      <= state_next;
            col_reg        <= col_next;
            row_reg        <= row_next;
            drain_reg      <= drain_next;
            frame_done_reg <= frame_done_next;
            win_valid_reg  <= issue;
            if (issue) begin
                win_x_reg <= win_x_next;
                win_y_reg <= win_y_next;
            end
        end
    end

    // Read address tracks the column of the next beat, so the registered read is ready in time.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            lb_a[col_reg[AW-1:0]] <= rd_b_reg;
            lb_b[col_reg[AW-1:0]] <= pix_in;
        end
        rd_a_reg <= lb_a[col_next[AW-1:0]];
        rd_b_reg <= lb_b[col_next[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_reg[i][j] <= 8'h00;
                end
            end
        end else if (win_clear) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_reg[i][j] <= 8'h00;
                end
            end
        end else if (shift_en) begin
            for (int i = 0; i < 3; i++) begin
                win_reg[i][0] <= win_reg[i][1];
                win_reg[i][1] <= win_reg[i][2];
                win_reg[i][2] <= col_in[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SOBEL_LAT; i++) begin
                dly_valid_reg[i] <= 1'b0;
                dly_x_reg[i]     <= 16'd0;
                dly_y_reg[i]     <= 16'd0;
            end
        end else begin
            dly_valid_reg[0] <= win_valid_reg;
            dly_x_reg[0]     <= win_x_reg;
            dly_y_reg[0]     <= win_y_reg;
            for (int i = 1; i < SOBEL_LAT; i++) begin
                dly_valid_reg[i] <= dly_valid_reg[i-1];
                dly_x_reg[i]     <= dly_x_reg[i-1];
                dly_y_reg[i]     <= dly_y_reg[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_reg <= 1'b0;
            out_mag_reg   <= 8'h00;
            out_dir_reg   <= 1'b0;
            out_x_reg     <= 16'd0;
            out_y_reg     <= 16'd0;
        end else begin
            out_valid_reg <= dly_valid_reg[SOBEL_LAT-1];
            if (dly_valid_reg[SOBEL_LAT-1]) begin
                out_mag_reg <= grad_mag;
                out_dir_reg <= grad_dir;
                out_x_reg   <= dly_x_reg[SOBEL_LAT-1];
                out_y_reg   <= dly_y_reg[SOBEL_LAT-1];
            end
        end
    end

    assign p00        = win_reg[0][0];
    assign p01        = win_reg[0][1];
    assign p02        = win_reg[0][2];
    assign p10        = win_reg[1][0];
    assign p11        = win_reg[1][1];
    assign p12        = win_reg[1][2];
    assign p20        = win_reg[2][0];
    assign p21        = win_reg[2][1];
    assign p22        = win_reg[2][2];
    assign win_valid  = win_valid_reg;
    assign out_valid  = out_valid_reg;
    assign out_mag    = out_mag_reg;
    assign out_dir    = out_dir_reg;
    assign out_x      = out_x_reg;
    assign out_y      = out_y_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_sobel_window_controller.sv
// Scoreboard bench: expected windows/outputs come from a zero-padded image model and are
// checked by a monitor as the controller emits them; a hash stand-in plays sobel_operator.
module tb_sobel_window_controller;
    localparam int W       = 4;
    localparam int H       = 3;
    localparam int LAT     = 2;
    localparam int NPIX    = W * H;
    localparam int EXP_LAT = NPIX + (H - 1) + (W + 1) + LAT + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  pix_in = 8'h00;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [7:0]  p00, p01, p02, p10, p11, p12, p20, p21, p22;
    logic        win_valid;
    logic [7:0]  grad_mag;
    logic        grad_dir;
    logic        out_valid;
    logic [7:0]  out_mag;
    logic        out_dir;
    logic [15:0] out_x, out_y;
    logic        busy, frame_done;

    always #5 clk = ~clk;

    sobel_window_controller #(.IMG_W(W), .IMG_H(H), .SOBEL_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .p00(p00), .p01(p01), .p02(p02), .p10(p10), .p11(p11), .p12(p12),
        .p20(p20), .p21(p21), .p22(p22),
        .win_valid(win_valid), .grad_mag(grad_mag), .grad_dir(grad_dir),
        .out_valid(out_valid), .out_mag(out_mag), .out_dir(out_dir),
        .out_x(out_x), .out_y(out_y), .busy(busy), .frame_done(frame_done)
    );

    typedef struct { logic [71:0] w; int x; int y; } win_exp_t;
    typedef struct { logic [7:0] mag; logic dir; int x; int y; } out_exp_t;

    win_exp_t    win_q[$];
    out_exp_t    out_q[$];
    logic [7:0]  img [NPIX];
    logic [71:0] cap_win [NPIX];
    logic [71:0] win_pack;
    logic [8:0]  op_pipe [LAT];
    win_exp_t    we;
    out_exp_t    oe;
    int errors = 0, checks = 0;
    int cyc = 0, win_cnt = 0, out_cnt = 0, done_cnt = 0;

    assign win_pack = {p00, p01, p02, p10, p11, p12, p20, p21, p22};

    // Position-sensitive stand-in for the operator so any window/coordinate skew shows up.
    function automatic logic [8:0] op_fn(input logic [71:0] w_in);
        logic [71:0] w;
        logic [7:0]  acc, b;
        logic        par;
        w = w_in; acc = 8'h00; par = 1'b0;
        for (int k = 0; k < 9; k++) begin
            b   = w[71:64];
            w   = w << 8;
            acc = acc + ((b ^ 8'(k * 29)) * 8'(2 * k + 1));
            par = par ^ b[3'(k)];
        end
        return {par, acc};
    endfunction

    function automatic logic [71:0] ref_win(input int y, input int x);
        logic [71:0] w;
        logic [7:0]  v;
        int yy, xx;
        w = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                yy = y - 1 + i;
                xx = x - 1 + j;
                v  = (yy >= 0 && yy < H && xx >= 0 && xx < W) ? img[yy * W + xx] : 8'h00;
                w  = {w[63:0], v};
            end
        end
        return w;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        op_pipe[0] <= op_fn(win_pack);
        for (int i = 1; i < LAT; i++) op_pipe[i] <= op_pipe[i-1];
    end
    assign grad_mag = op_pipe[LAT-1][7:0];
    assign grad_dir = op_pipe[LAT-1][8];

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (win_valid) begin
                win_cnt++;
                if (win_q.size() == 0) begin
                    check("win_unexpected", 72'(win_valid), 72'd0);
                end else begin
                    we = win_q.pop_front();
                    check($sformatf("win(%0d,%0d)", we.y, we.x), win_pack, we.w);
                    cap_win[we.y * W + we.x] = win_pack;
                end
            end
            if (out_valid) begin
                out_cnt++;
                $display("out y=%0d x=%0d mag=%02h dir=%0d", out_y, out_x, out_mag, out_dir);
                if (out_q.size() == 0) begin
                    check("out_unexpected", 72'(out_valid), 72'd0);
                end else begin
                    oe = out_q.pop_front();
                    check($sformatf("out(%0d,%0d)", oe.y, oe.x),
                          72'({out_mag, out_dir, out_x, out_y}),
                          72'({oe.mag, oe.dir, 16'(oe.x), 16'(oe.y)}));
                end
            end
            if (frame_done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_image(input int mode);
        logic [71:0] wv;
        logic [8:0]  h;
        for (int i = 0; i < NPIX; i++) begin
            img[i]     = (mode == 0) ? 8'h10 : (mode == 1) ? 8'(i) : 8'($urandom_range(0, 255));
            cap_win[i] = '1;
        end
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                wv = ref_win(y, x);
                h  = op_fn(wv);
                win_q.push_back('{w: wv, x: x, y: y});
                out_q.push_back('{mag: h[7:0], dir: h[8], x: x, y: y});
            end
        end
    endtask

    task automatic send_pixels(input int count, input bit gaps, input int start_at);
        bit rdy;
        int waited;
        for (int i = 0; i < count; i++) begin
            if (gaps) begin
                for (int g = 0; g < 8; g++) begin
                    if ($urandom_range(0, 1) == 0) break;
                    pix_valid = 1'b0;
                    tick();
                end
            end
            pix_valid = 1'b1;
            pix_in    = img[i];
            if (i == start_at) start = 1'b1;
            waited = 0;
            rdy    = 1'b0;
            while (!rdy && waited < 100) begin
                @(negedge clk);
                rdy = pix_ready;
                tick();
                waited++;
            end
            start = 1'b0;
            check("beat_accepted", 72'(rdy), 72'd1);
        end
        pix_valid = 1'b0;
    endtask

    task automatic run_frame(input int mode, input bit gaps, input bit busy_start, input bit coinc);
        int w0, o0, d0, c0, tdone;
        bit seen;
        load_image(mode);
        w0 = win_cnt; o0 = out_cnt; d0 = done_cnt;
        tick();
        start = 1'b1;
        c0 = cyc;
        tick();
        start = 1'b0;
        check("busy_after_start", 72'(busy), 72'd1);
        send_pixels(NPIX, gaps, busy_start ? 5 : -1);
        seen = 1'b0; tdone = 0;
        for (int k = 0; k < 500 && !seen; k++) begin
            @(negedge clk);
            if (frame_done) begin
                seen  = 1'b1;
                tdone = cyc;
            end
        end
        check("frame_done_seen", 72'(seen), 72'd1);
        if (coinc && seen) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            check("start_at_done_ignored", 72'(busy), 72'd0);
        end
        if (!gaps && seen) check("frame_latency", 72'(tdone - c0), 72'(EXP_LAT));
        repeat ((busy_start || coinc) ? 40 : 3) tick();
        check("win_count", 72'(win_cnt - w0), 72'(NPIX));
        check("out_count", 72'(out_cnt - o0), 72'(NPIX));
        check("done_count", 72'(done_cnt - d0), 72'd1);
        check("queues_empty", 72'(win_q.size() + out_q.size()), 72'd0);
        check("idle_busy", 72'(busy), 72'd0);
    endtask

    initial begin
        int d0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 72'({pix_ready, win_valid, out_valid, busy, frame_done,
                                     out_mag, out_dir, out_x, out_y}), 72'd0);
        check("reset_window", win_pack, 72'd0);
        rst = 1'b1;
        tick();
        check("idle_ready", 72'({pix_ready, busy}), 72'd0);

        run_frame(0, 1'b0, 1'b0, 1'b0);
        check("const_interior", cap_win[1 * W + 1], {9{8'h10}});
        check("const_corner", cap_win[0], 72'h00_00_00_00_10_10_00_10_10);

        run_frame(1, 1'b0, 1'b0, 1'b0);
        check("ramp_1_1", cap_win[1 * W + 1], 72'h00_01_02_04_05_06_08_09_0A);
        check("ramp_2_3", cap_win[2 * W + 3], 72'h06_07_00_0A_0B_00_00_00_00);

        run_frame(1, 1'b1, 1'b0, 1'b0);
        check("ramp_gaps_1_1", cap_win[1 * W + 1], 72'h00_01_02_04_05_06_08_09_0A);
        check("ramp_gaps_2_3", cap_win[2 * W + 3], 72'h06_07_00_0A_0B_00_00_00_00);

        for (int f = 0; f < 3; f++) run_frame(2, 1'b1, 1'b0, 1'b0);
        run_frame(2, 1'b0, 1'b1, 1'b0);
        run_frame(2, 1'b0, 1'b0, 1'b1);

        // Abort in the middle of input row 1, then rerun a golden frame.
        load_image(2);
        d0 = done_cnt;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        send_pixels(W + 2, 1'b0, -1);
        rst = 1'b0;
        #1;
        check("abort_outputs", 72'({pix_ready, win_valid, out_valid, busy, frame_done,
                                     out_mag, out_dir, out_x, out_y}), 72'd0);
        check("abort_window", win_pack, 72'd0);
        repeat (2) tick();
        win_q.delete();
        out_q.delete();
        rst = 1'b1;
        repeat (60) tick();
        check("abort_no_done", 72'(done_cnt - d0), 72'd0);
        run_frame(1, 1'b0, 1'b0, 1'b0);
        check("rerun_ramp_1_1", cap_win[1 * W + 1], 72'h00_01_02_04_05_06_08_09_0A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
